mem_access_unit: RTL

//  Multi-cycle load/store unit between the execute stage and the data-memory bus.

---
 rtl/mem_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Multi-cycle load/store unit sitting between the execute stage and the data
// memory bus. One access at a time: the request fields are latched in IDLE,
// presented on the bus in REQ, the response is awaited in WAIT (with a timeout),
// and the result is reported for exactly one cycle in DONE. While the access is
// in flight the upstream pipeline is held via stall.
//
// Build option:
//   MISALIGN_CHECK_EN  defined   -> misaligned accesses skip the bus and finish
//                                   immediately with misalign=1 and data 0.
//                      undefined -> misalign tied 0; the low offset bits are
//                                   forced aligned to the access size.
//
// Parameters:
//   TIMEOUT_CYC     max WAIT cycles before a bus error is declared (1..255)
//
// Ports:
//   clk             core clock, rising edge
//   rstn            asynchronous active-low reset
//   req_valid       memory instruction present in this stage
//   req_we          1 = store, 0 = load
//   req_funct3      RV64 width/sign code
//   req_addr        effective address
//   req_wdata       store data (rs2)
//   stall           hold upstream pipeline
//   done            access complete this cycle
//   wb_mem_data     extended load result (0 after store / error)
//   bus_err         timeout indication, pulses with done
//   misalign        misaligned access indication, pulses with done
//   mem_req_valid   bus request valid
//   mem_req_ready   bus accepts request
//   mem_addr        doubleword-aligned bus address
//   mem_wen         bus write enable
//   mem_wmask       byte strobes
//   mem_wdata       store data shifted into its byte lanes
//   mem_resp_valid  bus response / ack
//   mem_resp_data   read doubleword
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [63:0] wb_mem_data,
    output logic        bus_err,
    output logic        misalign,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] TIMEOUT_VAL = TIMEOUT_CYC[7:0];

    // -------------------------------------------------------------------------
    // State and latched request fields
    // -------------------------------------------------------------------------
    logic [1:0]  state_reg,   state_next;
    logic        we_reg,      we_next;
    logic [2:0]  funct3_reg,  funct3_next;
    logic [2:0]  off_reg,     off_next;
    logic [60:0] addr_hi_reg, addr_hi_next;
    logic [63:0] wdata_reg,   wdata_next;
    logic [7:0]  cnt_reg,     cnt_next;
    logic [63:0] wb_data_reg, wb_data_next;
    logic        bus_err_reg, bus_err_next;

    // -------------------------------------------------------------------------
    // Request-side offset decode. The offset is aligned down to the access size
    // before it is latched; for an already aligned access this is a no-op.
    // -------------------------------------------------------------------------
    logic [2:0] req_off;
    logic [2:0] req_off_aligned;

    assign req_off = req_addr[2:0];

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_off_aligned = req_off;
            2'b01:   req_off_aligned = {req_off[2:1], 1'b0};
            2'b10:   req_off_aligned = {req_off[2], 2'b00};
            default: req_off_aligned = 3'b000;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    logic misalign_reg, misalign_next;
    logic req_misaligned;

    // funct3=111 has no defined width, so it is never reported as misaligned.
    assign req_misaligned = (req_funct3 != 3'b111) && (req_off != req_off_aligned);
`endif

    // -------------------------------------------------------------------------
    // Load extraction: shift the addressed bytes down to bit 0, then extend.
    // -------------------------------------------------------------------------
    logic [63:0] resp_shifted;
    logic [63:0] load_ext;

    assign resp_shifted = mem_resp_data >> {off_reg, 3'b000};

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{56{resp_shifted[7]}},  resp_shifted[7:0]};
            3'b001:  load_ext = {{48{resp_shifted[15]}}, resp_shifted[15:0]};
            3'b010:  load_ext = {{32{resp_shifted[31]}}, resp_shifted[31:0]};
            3'b011:  load_ext = resp_shifted;
            3'b100:  load_ext = {56'd0, resp_shifted[7:0]};
            3'b101:  load_ext = {48'd0, resp_shifted[15:0]};
            3'b110:  load_ext = {32'd0, resp_shifted[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Store byte strobes: lane gi is enabled when it falls inside
    // [off, off + size). Store codes with funct3[2] set have no width and
    // therefore write no bytes.
    // -------------------------------------------------------------------------
    logic [3:0] lane_bytes;
    logic [3:0] lane_end;
    logic       lane_en;
    logic [7:0] lane_mask;

    always_comb begin
        case (funct3_reg[1:0])
            2'b00:   lane_bytes = 4'd1;
            2'b01:   lane_bytes = 4'd2;
            2'b10:   lane_bytes = 4'd4;
            default: lane_bytes = 4'd8;
        endcase
    end

    assign lane_end = {1'b0, off_reg} + lane_bytes;
    assign lane_en  = we_reg && !funct3_reg[2];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_mask[gi] = lane_en
                                && (4'(gi) >= {1'b0, off_reg})
                                && (4'(gi) < lane_end);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt_reg + 8'd1;

    always_comb begin
        state_next   = state_reg;
        we_next      = we_reg;
        funct3_next  = funct3_reg;
        off_next     = off_reg;
        addr_hi_next = addr_hi_reg;
        wdata_next   = wdata_reg;
        cnt_next     = cnt_reg;
        wb_data_next = wb_data_reg;
        // Status flags are only ever set on the transition into DONE, so they
        // naturally last exactly the one DONE cycle.
        bus_err_next = 1'b0;
`ifdef MISALIGN_CHECK_EN
        misalign_next = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    we_next      = req_we;
                    funct3_next  = req_funct3;
                    off_next     = req_off_aligned;
                    addr_hi_next = req_addr[63:3];
                    wdata_next   = req_wdata;
                    cnt_next     = 8'd0;
`ifdef MISALIGN_CHECK_EN
                    if (req_misaligned) begin
                        state_next    = ST_DONE;
                        misalign_next = 1'b1;
                        wb_data_next  = 64'd0;
                    end else begin
                        state_next = ST_REQ;
                    end
`else
                    state_next = ST_REQ;
`endif
                end
            end

            ST_REQ: begin
                if (mem_req_ready) begin
                    state_next = ST_WAIT;
                    cnt_next   = 8'd0;
                end
            end

            ST_WAIT: begin
                cnt_next = cnt_inc;
                // A response in the same cycle as the timeout takes priority.
                if (mem_resp_valid) begin
                    state_next   = ST_DONE;
                    wb_data_next = we_reg ? 64'd0 : load_ext;
                end else if (cnt_inc == TIMEOUT_VAL) begin
                    state_next   = ST_DONE;
                    bus_err_next = 1'b1;
                    wb_data_next = 64'd0;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            we_reg      <= 1'b0;
            funct3_reg  <= 3'd0;
            off_reg     <= 3'd0;
            addr_hi_reg <= 61'd0;
            wdata_reg   <= 64'd0;
            cnt_reg     <= 8'd0;
            wb_data_reg <= 64'd0;
            bus_err_reg <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            we_reg      <= we_next;
            funct3_reg  <= funct3_next;
            off_reg     <= off_next;
            addr_hi_reg <= addr_hi_next;
            wdata_reg   <= wdata_next;
            cnt_reg     <= cnt_next;
            wb_data_reg <= wb_data_next;
            bus_err_reg <= bus_err_next;
`ifdef MISALIGN_CHECK_EN
            misalign_reg <= misalign_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Bus fields are only driven while the request is presented so
    // the bus sees zeros whenever mem_req_valid is low.
    // -------------------------------------------------------------------------
    logic in_req;

    assign in_req = (state_reg == ST_REQ);

    assign stall = ((state_reg == ST_IDLE) && req_valid)
                || in_req
                || (state_reg == ST_WAIT);
    assign done        = (state_reg == ST_DONE);
    assign wb_mem_data = wb_data_reg;
    assign bus_err     = bus_err_reg;

`ifdef MISALIGN_CHECK_EN
    assign misalign = misalign_reg;
`else
    assign misalign = 1'b0;
`endif

    assign mem_req_valid = in_req;
    assign mem_addr      = in_req ? {addr_hi_reg, 3'b000} : 64'd0;
    assign mem_wen       = in_req && we_reg;
    assign mem_wmask     = in_req ? lane_mask : 8'd0;
    assign mem_wdata     = in_req ? (wdata_reg << {off_reg, 3'b000}) : 64'd0;

endmodule
